// File: rtl/qbert_gfx_pkg.sv
// Shared widths, state encoding and command types for the Q*bert sprite blitter.
package qbert_gfx_pkg;

  localparam int PIX_W      = 16;
  localparam int PIC_AW     = 12;
  localparam int BG_AW      = 13;
  localparam int SRC_AW     = PIC_AW;
  localparam int DST_AW     = BG_AW;
  localparam int DW         = PIX_W;
  localparam int DIM_W      = 6;
  localparam int DST_STRIDE = 128;

  localparam logic [PIX_W-1:0] KEY_MAGENTA = 16'hF81F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } blit_state_t;

  typedef struct packed {
    logic             key_en;
    logic [PIX_W-1:0] key;
  } blit_key_t;

  typedef struct packed {
    logic [PIC_AW-1:0] src_base;
    logic [BG_AW-1:0]  dst_base;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    blit_key_t         key;
  } blit_cmd_t;

  function automatic logic cmd_is_empty(input blit_cmd_t cmd);
    return (cmd.width == '0) || (cmd.height == '0);
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Raster walker for one blit: source pointer, destination row/column and
// the flag marking the final pixel of the sprite.
module blit_addr_gen
  import qbert_gfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [DST_AW-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [SRC_AW-1:0] src_ptr,
  output logic [DST_AW-1:0] dst_addr,
  output logic              last
);

  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  x_q, x_d;
  logic [DIM_W-1:0]  y_q, y_d;
  logic [SRC_AW-1:0] src_ptr_q, src_ptr_d;
  logic [DST_AW-1:0] dst_row_q, dst_row_d;
  logic              x_end;

  assign x_end    = (x_q == width_q - DIM_W'(1));
  assign last     = x_end && (y_q == height_q - DIM_W'(1));
  assign src_ptr  = src_ptr_q;
  assign dst_addr = dst_row_q + DST_AW'(x_q);

  always_comb begin
    // NOTE: every output gets its hold value first, so no path leaves it unassigned (no latch).
    width_d   = width_q;
    height_d  = height_q;
    x_d       = x_q;
    y_d       = y_q;
    src_ptr_d = src_ptr_q;
    dst_row_d = dst_row_q;
    if (load) begin
      width_d   = width;
      height_d  = height;
      x_d       = '0;
      y_d       = '0;
      src_ptr_d = src_base;
      dst_row_d = dst_base;
    end else if (step) begin
      src_ptr_d = src_ptr_q + SRC_AW'(1);
      if (x_end) begin
        x_d       = '0;
        y_d       = y_q + DIM_W'(1);
        dst_row_d = dst_row_q + DST_AW'(DST_STRIDE);
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q   <= '0;
      height_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      src_ptr_q <= '0;
      dst_row_q <= '0;
    end else begin
      width_q   <= width_d;
      height_q  <= height_d;
      x_q       <= x_d;
      y_q       <= y_d;
      src_ptr_q <= src_ptr_d;
      dst_row_q <= dst_row_d;
    end
  end

endmodule

// File: rtl/qbert_sprite_blitter.sv
// Command-driven sprite blitter: pic_mem -> background_mem, one pixel per
// cycle, optional colour-key transparency, stalls on a missing bg_grant.
module qbert_sprite_blitter
  import qbert_gfx_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SRC_AW-1:0] cmd_src_base,
  input  logic [DST_AW-1:0] cmd_dst_base,
  input  logic [DIM_W-1:0]  cmd_width,
  input  logic [DIM_W-1:0]  cmd_height,
  input  logic              cmd_key_en,
  input  logic [DW-1:0]     cmd_key,
  input  logic              bg_grant,
  output logic              busy,
  output logic              done,
  output logic [SRC_AW-1:0] pic_mem_s2_address,
  output logic              pic_mem_s2_chipselect,
  output logic              pic_mem_s2_clken,
  output logic              pic_mem_s2_write,
  input  logic [DW-1:0]     pic_mem_s2_readdata,
  output logic [DW-1:0]     pic_mem_s2_writedata,
  output logic [1:0]        pic_mem_s2_byteenable,
  output logic [DST_AW-1:0] background_mem_s2_address,
  output logic              background_mem_s2_chipselect,
  output logic              background_mem_s2_clken,
  output logic              background_mem_s2_write,
  output logic [DW-1:0]     background_mem_s2_writedata,
  output logic [1:0]        background_mem_s2_byteenable
);

  blit_state_t       state_q, state_d;
  blit_key_t         key_q, key_d;
  blit_cmd_t         cmd_in;

  logic              accept;
  logic              stall;
  logic              issue;
  logic              keyed;
  logic              last;
  logic [SRC_AW-1:0] src_ptr;
  logic [DST_AW-1:0] dst_addr;

  logic              s1_vld_q, s1_vld_d;
  logic [DST_AW-1:0] s1_dst_q, s1_dst_d;
  logic              s2_vld_q, s2_vld_d;
  logic [DST_AW-1:0] s2_dst_q, s2_dst_d;
  logic [DW-1:0]     pix_q, pix_d;

  always_comb begin
    cmd_in.src_base   = cmd_src_base;
    cmd_in.dst_base   = cmd_dst_base;
    cmd_in.width      = cmd_width;
    cmd_in.height     = cmd_height;
    cmd_in.key.key_en = cmd_key_en;
    cmd_in.key.key    = cmd_key;
  end

  // A stall only exists while a write is actually waiting in S2.
  assign stall  = s2_vld_q && !bg_grant;
  assign accept = (state_q == ST_IDLE) && cmd_valid;
  assign issue  = (state_q == ST_RUN) && !stall;
  assign keyed  = key_q.key_en && (pix_q == key_q.key);

  blit_addr_gen u_addr_gen (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .load     (accept),
    .step     (issue),
    .src_base (cmd_in.src_base),
    .dst_base (cmd_in.dst_base),
    .width    (cmd_in.width),
    .height   (cmd_in.height),
    .src_ptr  (src_ptr),
    .dst_addr (dst_addr),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          key_d   = cmd_in.key;
          state_d = cmd_is_empty(cmd_in) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as the final S2 write retires so done lands the next cycle.
        if (!s1_vld_q && (!s2_vld_q || !stall)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dst_d = s1_dst_q;
    s2_vld_d = s2_vld_q;
    s2_dst_d = s2_dst_q;
    pix_d    = pix_q;
    if (!stall) begin
      s1_vld_d = issue;
      s1_dst_d = dst_addr;
      s2_vld_d = s1_vld_q;
      s2_dst_d = s1_dst_q;
      if (s1_vld_q) pix_d = pic_mem_s2_readdata;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_dst_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dst_q <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      s1_vld_q <= s1_vld_d;
      s1_dst_q <= s1_dst_d;
      s2_vld_q <= s2_vld_d;
      s2_dst_q <= s2_dst_d;
      pix_q    <= pix_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  // The RAM output register freezes with clken, so held readdata stays valid.
  assign pic_mem_s2_address    = src_ptr;
  assign pic_mem_s2_chipselect = (state_q == ST_RUN);
  assign pic_mem_s2_clken      = !stall;
  assign pic_mem_s2_write      = 1'b0;
  assign pic_mem_s2_writedata  = '0;
  assign pic_mem_s2_byteenable = 2'b11;

  assign background_mem_s2_address    = s2_dst_q;
  assign background_mem_s2_chipselect = s2_vld_q && !stall;
  assign background_mem_s2_clken      = !stall;
  assign background_mem_s2_write      = s2_vld_q && !stall && !keyed;
  assign background_mem_s2_writedata  = pix_q;
  assign background_mem_s2_byteenable = 2'b11;

endmodule

// File: tb/tb_qbert_sprite_blitter.sv
// Self-checking bench: directed and randomized blits against a raster-order
// reference model with a grant-driven slot timing model.
module tb_qbert_sprite_blitter;
  import qbert_gfx_pkg::*;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SRC_AW-1:0] cmd_src_base;
  logic [DST_AW-1:0] cmd_dst_base;
  logic [DIM_W-1:0]  cmd_width;
  logic [DIM_W-1:0]  cmd_height;
  logic              cmd_key_en;
  logic [DW-1:0]     cmd_key;
  logic              bg_grant;
  logic              busy;
  logic              done;
  logic [SRC_AW-1:0] pic_addr;
  logic              pic_cs;
  logic              pic_clken;
  logic              pic_wr;
  logic [DW-1:0]     pic_rdata = '0;
  logic [DW-1:0]     pic_wdata;
  logic [1:0]        pic_be;
  logic [DST_AW-1:0] bg_addr;
  logic              bg_cs;
  logic              bg_clken;
  logic              bg_wr;
  logic [DW-1:0]     bg_wdata;
  logic [1:0]        bg_be;

  qbert_sprite_blitter dut (
    .clk_clk                      (clk_clk),
    .reset_reset_n                (reset_reset_n),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_src_base                 (cmd_src_base),
    .cmd_dst_base                 (cmd_dst_base),
    .cmd_width                    (cmd_width),
    .cmd_height                   (cmd_height),
    .cmd_key_en                   (cmd_key_en),
    .cmd_key                      (cmd_key),
    .bg_grant                     (bg_grant),
    .busy                         (busy),
    .done                         (done),
    .pic_mem_s2_address           (pic_addr),
    .pic_mem_s2_chipselect        (pic_cs),
    .pic_mem_s2_clken             (pic_clken),
    .pic_mem_s2_write             (pic_wr),
    .pic_mem_s2_readdata          (pic_rdata),
    .pic_mem_s2_writedata         (pic_wdata),
    .pic_mem_s2_byteenable        (pic_be),
    .background_mem_s2_address    (bg_addr),
    .background_mem_s2_chipselect (bg_cs),
    .background_mem_s2_clken      (bg_clken),
    .background_mem_s2_write      (bg_wr),
    .background_mem_s2_writedata  (bg_wdata),
    .background_mem_s2_byteenable (bg_be)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int                cyc;
    logic [DST_AW-1:0] addr;
    logic [DW-1:0]     data;
    logic              wr;
  } ev_t;

  logic [DW-1:0] pic_mem [0:(1<<SRC_AW)-1];
  bit            gs [0:2047];
  int            n_vec = 0;
  int            n_err = 0;

  // Registered-output sprite RAM, frozen while clken is low.
  always @(posedge clk_clk) if (pic_clken) pic_rdata <= pic_mem[pic_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic grant_all();
    for (int i = 0; i < 2048; i++) gs[i] = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    32'(cmd_ready), 1);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_pic_cs"},   32'(pic_cs), 0);
    check({tag, "_pic_wr"},   32'(pic_wr), 0);
    check({tag, "_pic_addr"}, 32'(pic_addr), 0);
    check({tag, "_pic_wd"},   32'(pic_wdata), 0);
    check({tag, "_pic_ck"},   32'(pic_clken), 1);
    check({tag, "_bg_cs"},    32'(bg_cs), 0);
    check({tag, "_bg_wr"},    32'(bg_wr), 0);
    check({tag, "_bg_addr"},  32'(bg_addr), 0);
    check({tag, "_bg_wd"},    32'(bg_wdata), 0);
    check({tag, "_bg_ck"},    32'(bg_clken), 1);
  endtask

  task automatic run_blit(input logic [SRC_AW-1:0] src, input logic [DST_AW-1:0] dst,
                          input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h,
                          input logic key_en, input logic [DW-1:0] key,
                          input int inject_at, input string tag,
                          output int done_o, output int nwr_o);
    ev_t               exp_q[$];
    ev_t               got_q[$];
    logic [SRC_AW-1:0] exp_rd[$];
    logic [SRC_AW-1:0] got_rd[$];
    ev_t               ev;
    logic [31:0]       tmp;
    int n, prev, cand, exp_done, exp_stalls, rel, done_rel, n_done, stall_cnt, side_bad;
    bit ready_ok;
    n = int'(w) * int'(h);
    prev = 2;
    for (int k = 0; k < n; k++) begin
      tmp = 32'(src) + 32'(k);
      exp_rd.push_back(tmp[SRC_AW-1:0]);
      tmp = 32'(dst) + 32'((k / int'(w)) * DST_STRIDE + (k % int'(w)));
      ev.addr = tmp[DST_AW-1:0];
      ev.data = pic_mem[exp_rd[k]];
      ev.wr   = !(key_en && (ev.data == key));
      cand = (k + 3 > prev + 1) ? k + 3 : prev + 1;
      while (cand < 2047 && !gs[cand]) cand++;
      ev.cyc = cand;
      prev = cand;
      exp_q.push_back(ev);
    end
    exp_done   = (n == 0) ? 1 : prev + 1;
    exp_stalls = (n == 0) ? 0 : prev - (n + 2);

    @(posedge clk_clk); #1;
    cmd_src_base = src; cmd_dst_base = dst; cmd_width = w; cmd_height = h;
    cmd_key_en = key_en; cmd_key = key; cmd_valid = 1'b1; bg_grant = gs[0];
    rel = 0; done_rel = -1; n_done = 0; stall_cnt = 0; side_bad = 0; ready_ok = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (rel == 0) begin
        check({tag, "_c0_ready"}, 32'(cmd_ready), 1);
        check({tag, "_c0_busy"},  32'(busy), 0);
      end
      if (bg_cs) begin
        ev.cyc = rel; ev.addr = bg_addr; ev.data = bg_wdata; ev.wr = bg_wr;
        got_q.push_back(ev);
        if (bg_be != 2'b11) side_bad++;
      end
      if (pic_cs && pic_clken) got_rd.push_back(pic_addr);
      if (!bg_clken) stall_cnt++;
      if (bg_clken != pic_clken || pic_wr || pic_wdata != '0 || pic_be != 2'b11) side_bad++;
      if (done) begin
        n_done++;
        if (done_rel < 0) done_rel = rel;
      end
      if (done_rel >= 0 && rel == done_rel + 1) begin
        ready_ok = cmd_ready && !busy;
        break;
      end
      if (rel > exp_done + 40) break;
      @(posedge clk_clk); #1;
      rel++;
      cmd_valid = (rel == inject_at);
      if (rel == inject_at) begin
        cmd_src_base = ~src; cmd_dst_base = ~dst; cmd_width = 6'd2; cmd_height = 6'd2;
      end
      bg_grant = (rel < 2048) ? gs[rel] : 1'b1;
    end
    cmd_valid = 1'b0;
    bg_grant  = 1'b1;
    @(negedge clk_clk);
    check({tag, "_idle_after"}, 32'(busy), 0);

    check({tag, "_done_cyc"},  32'(done_rel), 32'(exp_done));
    check({tag, "_done_cnt"},  32'(n_done), 1);
    check({tag, "_ready"},     32'(ready_ok), 1);
    check({tag, "_stalls"},    32'(stall_cnt), 32'(exp_stalls));
    check({tag, "_side"},      32'(side_bad), 0);
    check({tag, "_n_slots"},   32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_n_reads"},   32'(got_rd.size()), 32'(exp_rd.size()));
    nwr_o = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_ev%0d_cyc", tag, i),  32'(got_q[i].cyc),  32'(exp_q[i].cyc));
      check($sformatf("%s_ev%0d_addr", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_ev%0d_data", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_ev%0d_wr", tag, i),   32'(got_q[i].wr),   32'(exp_q[i].wr));
      if (got_q[i].wr) nwr_o++;
    end
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
    done_o = done_rel;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, nw, bad;
    logic [SRC_AW-1:0] rs;
    logic [DIM_W-1:0]  rw, rh;
    reset_reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_src_base = '0; cmd_dst_base = '0; cmd_width = '0;
    cmd_height = '0; cmd_key_en = 1'b0; cmd_key = '0; bg_grant = 1'b1;
    for (int i = 0; i < (1 << SRC_AW); i++) pic_mem[i] = DW'($urandom);
    grant_all();
    repeat (3) @(posedge clk_clk);
    #1;
    check_reset_outputs("por");
    reset_reset_n = 1'b1;

    run_blit(12'h010, 13'h0000, 6'd4, 6'd2, 1'b0, 16'h0000, -1, "plain", d, nw);
    check("plain_done11", 32'(d), 11);
    check("plain_nwr", 32'(nw), 8);

    for (int i = 16'h010; i < 16'h018; i++)
      if (pic_mem[i] == KEY_MAGENTA) pic_mem[i] = pic_mem[i] ^ 16'h0001;
    pic_mem[12'h012] = KEY_MAGENTA;
    pic_mem[12'h016] = KEY_MAGENTA;
    run_blit(12'h010, 13'h0000, 6'd4, 6'd2, 1'b1, KEY_MAGENTA, -1, "keyed", d, nw);
    check("keyed_done11", 32'(d), 11);
    check("keyed_nwr", 32'(nw), 6);

    run_blit(12'hFFE, 13'h1FFF, 6'd3, 6'd1, 1'b0, 16'h0000, -1, "wrap", d, nw);

    gs[4] = 1'b0; gs[5] = 1'b0; gs[6] = 1'b0;
    run_blit(12'h123, 13'h0456, 6'd4, 6'd1, 1'b0, 16'h0000, -1, "stall", d, nw);
    check("stall_done10", 32'(d), 10);
    grant_all();

    run_blit(12'h200, 13'h0300, 6'd0, 6'd5, 1'b0, 16'h0000, -1, "zero_w", d, nw);
    check("zero_w_done1", 32'(d), 1);
    run_blit(12'h200, 13'h0300, 6'd7, 6'd0, 1'b0, 16'h0000, -1, "zero_h", d, nw);
    run_blit(12'h400, 13'h0800, 6'd8, 6'd8, 1'b0, 16'h0000, 20, "inject", d, nw);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 2048; i++) gs[i] = ($urandom_range(0, 3) != 0);
      rs = SRC_AW'($urandom);
      rw = DIM_W'($urandom_range(1, 8));
      rh = DIM_W'($urandom_range(1, 6));
      run_blit(rs, DST_AW'($urandom), rw, rh, 1'($urandom_range(0, 1)),
               pic_mem[rs + SRC_AW'($urandom_range(0, 3))], -1, $sformatf("rnd%0d", t), d, nw);
    end
    grant_all();

    @(posedge clk_clk); #1;
    cmd_src_base = 12'h100; cmd_dst_base = 13'h0200; cmd_width = 6'd8; cmd_height = 6'd8;
    cmd_key_en = 1'b0; cmd_valid = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      @(posedge clk_clk); #1;
      cmd_valid = 1'b0;
    end
    check("rst_pre_cs", 32'(bg_cs), 1);
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    bad = 0;
    repeat (3) begin
      @(negedge clk_clk);
      if (bg_cs || bg_wr || done) bad++;
    end
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk_clk);
      if (bg_cs || bg_wr || done || busy || !cmd_ready) bad++;
    end
    check("rst_quiet", 32'(bad), 0);

    run_blit(12'hABC, 13'h1F80, 6'd5, 6'd3, 1'b0, 16'h0000, -1, "recover", d, nw);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
